// File: rtl/riscv_dp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_dp_pkg
//  Description : Shared types and default widths for the datapath blocks
//                around the register file write port.
//                Contents:
//                  arb_state_e   write-port arbiter state {ARB, STALL}
//                  C_DATA_WIDTH  default write data width
//                  C_ADDR_WIDTH  default register address width
//                  C_STARVE_MAX  default starvation limit for requester B
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_dp_pkg;

    localparam int unsigned C_DATA_WIDTH = 32;
    localparam int unsigned C_ADDR_WIDTH = 5;
    localparam int unsigned C_STARVE_MAX = 4;

    // ARB  : pipeline writeback has priority, B fills idle slots.
    // STALL: pipeline writeback is held off so B can drain.
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        STALL = 1'b1
    } arb_state_e;

endpackage : riscv_dp_pkg
`default_nettype wire

// File: rtl/riscv_dp_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_dp_scoreboard
//  Description : Pending-write scoreboard, one bit per architectural register.
//                A set marks a register as waiting on a long-latency result,
//                a clear retires it. Set wins over clear on the same register
//                in the same cycle. Register 0 can never be marked busy.
//                Both lookups read the current state (before this cycle's
//                set/clear take effect).
//  Ports       :
//    clk_i         clock
//    rst_i         asynchronous active-high reset, clears every bit
//    set_en_i      mark set_addr_i busy
//    set_addr_i    register to mark
//    clr_en_i      retire clr_addr_i
//    clr_addr_i    register to retire
//    chk_addr1_i   lookup address 1
//    chk_addr2_i   lookup address 2
//    busy1_o       chk_addr1_i currently pending
//    busy2_o       chk_addr2_i currently pending
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_dp_scoreboard
    import riscv_dp_pkg::*;
#(
    parameter int unsigned MP_ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     set_en_i,
    input  logic [MP_ADDR_WIDTH-1:0] set_addr_i,
    input  logic                     clr_en_i,
    input  logic [MP_ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [MP_ADDR_WIDTH-1:0] chk_addr1_i,
    input  logic [MP_ADDR_WIDTH-1:0] chk_addr2_i,
    output logic                     busy1_o,
    output logic                     busy2_o
);

    localparam int unsigned LP_REG_NUM = 2 ** MP_ADDR_WIDTH;

    logic [LP_REG_NUM-1:0] busy_q;
    logic [LP_REG_NUM-1:0] busy_d;

    // Clear is applied first so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1_o = busy_q[chk_addr1_i];
    assign busy2_o = busy_q[chk_addr2_i];

endmodule : riscv_dp_scoreboard
`default_nettype wire

// File: rtl/riscv_dp_regfile_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_dp_regfile_wr_arb
//  Description : Arbitrates the register file's single write port between
//                the pipeline writeback (A, cannot stall on its own) and a
//                long-latency unit (B, valid/ready). A always wins the port;
//                if B loses for too long the arbiter asserts ostall_a so the
//                pipeline holds writeback and B can drain. A pending-write
//                scoreboard tracks which registers still wait on B.
//  Ports       :
//    iclk, irst               clock, asynchronous active-high reset
//    ia_valid/ia_addr/ia_data writeback request (A)
//    ib_valid/ib_addr/ib_data long-latency request (B), ob_ready = accept
//    ialloc_valid/ialloc_addr mark a register pending on B
//    ichk_addr1/2, ochk_busy1/2 hazard lookups into the scoreboard
//    ostall_a                 registered hold request to the pipeline
//    oproto_err               1-cycle pulse: A wrote while ostall_a was high
//    owr_en3/owr_addr3/owr_data3 regfile write port 3
//  Configuration:
//    RISCV_REGFILE_WR_FWD_EN  adds ofwd_hit1/2 and ofwd_data1/2, a same-cycle
//                             bypass of the write being committed; a B write
//                             that hits a lookup also masks its busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_dp_regfile_wr_arb
    import riscv_dp_pkg::*;
#(
    parameter int unsigned MP_DATA_WIDTH = C_DATA_WIDTH,
    parameter int unsigned MP_ADDR_WIDTH = C_ADDR_WIDTH,
    // Must be >= 2.
    parameter int unsigned MP_STARVE_MAX = C_STARVE_MAX
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ia_valid,
    input  logic [MP_ADDR_WIDTH-1:0] ia_addr,
    input  logic [MP_DATA_WIDTH-1:0] ia_data,
    input  logic                     ib_valid,
    output logic                     ob_ready,
    input  logic [MP_ADDR_WIDTH-1:0] ib_addr,
    input  logic [MP_DATA_WIDTH-1:0] ib_data,
    input  logic                     ialloc_valid,
    input  logic [MP_ADDR_WIDTH-1:0] ialloc_addr,
    input  logic [MP_ADDR_WIDTH-1:0] ichk_addr1,
    output logic                     ochk_busy1,
    input  logic [MP_ADDR_WIDTH-1:0] ichk_addr2,
    output logic                     ochk_busy2,
    output logic                     ostall_a,
    output logic                     oproto_err,
    output logic                     owr_en3,
    output logic [MP_ADDR_WIDTH-1:0] owr_addr3,
    output logic [MP_DATA_WIDTH-1:0] owr_data3
`ifdef RISCV_REGFILE_WR_FWD_EN
    ,
    output logic                     ofwd_hit1,
    output logic [MP_DATA_WIDTH-1:0] ofwd_data1,
    output logic                     ofwd_hit2,
    output logic [MP_DATA_WIDTH-1:0] ofwd_data2
`endif
);

    // The counter saturates at the threshold, so it never needs more range.
    localparam int unsigned         LP_CNT_W      = $clog2(MP_STARVE_MAX) + 1;
    localparam logic [LP_CNT_W-1:0] LP_CNT_THRESH = LP_CNT_W'(MP_STARVE_MAX - 1);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [LP_CNT_W-1:0] cnt_q;
    logic [LP_CNT_W-1:0] cnt_d;
    logic [LP_CNT_W-1:0] w_cnt_inc;
    logic                ostall_q;
    logic                proto_q;

    logic                w_b_ready;
    logic                w_b_fire;
    logic                w_b_lose;
    logic                w_wr_req;
    logic                w_sb_busy1;
    logic                w_sb_busy2;
    logic                w_busy_mask1;
    logic                w_busy_mask2;

    // ------------------------------------------------------------------
    // Write port mux. A wins in both states: in STALL an A request is a
    // protocol violation, but pipeline data must never be dropped.
    // ------------------------------------------------------------------
    assign w_b_ready = ~irst & ~ia_valid;
    assign w_b_fire  = ib_valid & w_b_ready;
    assign w_b_lose  = ib_valid & ~w_b_ready;
    assign ob_ready  = w_b_ready;

    assign owr_addr3 = ia_valid ? ia_addr : ib_addr;
    assign owr_data3 = ia_valid ? ia_data : ib_data;
    assign w_wr_req  = ia_valid | w_b_fire;
    // x0 writes still complete their handshake but never reach the regfile.
    assign owr_en3   = ~irst & w_wr_req & (owr_addr3 != '0);

    // ------------------------------------------------------------------
    // Starvation counter and arbiter FSM
    // ------------------------------------------------------------------
    assign w_cnt_inc = cnt_q + 1'b1;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;

        if (w_b_fire) begin
            cnt_d = '0;
        end else if (w_b_lose && (cnt_q != LP_CNT_THRESH)) begin
            cnt_d = w_cnt_inc;
        end

        case (state_q)
            ARB: begin
                // Switch on the edge where the counter reaches the threshold.
                if (w_b_lose && (w_cnt_inc >= LP_CNT_THRESH)) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (w_b_fire) begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q  <= ARB;
            cnt_q    <= '0;
            ostall_q <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // Tracks the next state so ostall_a is a clean flop output.
            ostall_q <= (state_d == STALL);
            proto_q  <= ostall_q & ia_valid;
        end
    end

    assign ostall_a   = ostall_q;
    assign oproto_err = proto_q;

    // ------------------------------------------------------------------
    // Pending-write scoreboard. Only B retires entries; A writes target
    // registers that were never allocated to B.
    // ------------------------------------------------------------------
    riscv_dp_scoreboard #(
        .MP_ADDR_WIDTH (MP_ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i       (iclk),
        .rst_i       (irst),
        .set_en_i    (ialloc_valid),
        .set_addr_i  (ialloc_addr),
        .clr_en_i    (w_b_fire),
        .clr_addr_i  (ib_addr),
        .chk_addr1_i (ichk_addr1),
        .chk_addr2_i (ichk_addr2),
        .busy1_o     (w_sb_busy1),
        .busy2_o     (w_sb_busy2)
    );

`ifdef RISCV_REGFILE_WR_FWD_EN
    assign ofwd_hit1    = owr_en3 & (owr_addr3 == ichk_addr1) & (ichk_addr1 != '0);
    assign ofwd_hit2    = owr_en3 & (owr_addr3 == ichk_addr2) & (ichk_addr2 != '0);
    assign ofwd_data1   = owr_data3;
    assign ofwd_data2   = owr_data3;
    // The value is forwarded this cycle, so the hazard is already resolved.
    assign w_busy_mask1 = ofwd_hit1 & w_b_fire;
    assign w_busy_mask2 = ofwd_hit2 & w_b_fire;
`else
    assign w_busy_mask1 = 1'b0;
    assign w_busy_mask2 = 1'b0;
`endif

    assign ochk_busy1 = ~irst & w_sb_busy1 & ~w_busy_mask1;
    assign ochk_busy2 = ~irst & w_sb_busy2 & ~w_busy_mask2;

endmodule : riscv_dp_regfile_wr_arb
`default_nettype wire

// File: tb/tb_riscv_dp_regfile_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_dp_regfile_wr_arb
//  Description : Directed scoreboard bench for riscv_dp_regfile_wr_arb.
//                Stimulus pushes a per-cycle status expectation and any
//                expected regfile writes; a negedge monitor pops and checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_dp_regfile_wr_arb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    // status vector order: {hit1, hit2, ready, stall, perr, busy1, busy2}
    localparam logic [6:0] M_RSP = 7'b0011100;
    localparam logic [6:0] M_B1  = 7'b0000010;
    localparam logic [6:0] M_B2  = 7'b0000001;
    localparam logic [6:0] M_H   = 7'b1100000;
    localparam logic [6:0] M_ALL = 7'b0011111;
    localparam logic [6:0] V_RDY = 7'b0010000;
    localparam logic [6:0] V_STL = 7'b0001000;
    localparam logic [6:0] V_ERR = 7'b0000100;
    localparam logic [6:0] V_B1  = 7'b0000010;
    localparam logic [6:0] V_B2  = 7'b0000001;
    localparam logic [6:0] V_H2  = 7'b0100000;

    logic          iclk = 1'b0;
    logic          irst;
    logic          ia_valid;
    logic [AW-1:0] ia_addr;
    logic [DW-1:0] ia_data;
    logic          ib_valid;
    logic          ob_ready;
    logic [AW-1:0] ib_addr;
    logic [DW-1:0] ib_data;
    logic          ialloc_valid;
    logic [AW-1:0] ialloc_addr;
    logic [AW-1:0] ichk_addr1;
    logic          ochk_busy1;
    logic [AW-1:0] ichk_addr2;
    logic          ochk_busy2;
    logic          ostall_a;
    logic          oproto_err;
    logic          owr_en3;
    logic [AW-1:0] owr_addr3;
    logic [DW-1:0] owr_data3;
    logic          h1;
    logic          h2;
    logic [DW-1:0] fd2;

    always #5 iclk = ~iclk;

    riscv_dp_regfile_wr_arb #(
        .MP_DATA_WIDTH (DW),
        .MP_ADDR_WIDTH (AW),
        .MP_STARVE_MAX (4)
    ) dut (
        .iclk         (iclk),
        .irst         (irst),
        .ia_valid     (ia_valid),
        .ia_addr      (ia_addr),
        .ia_data      (ia_data),
        .ib_valid     (ib_valid),
        .ob_ready     (ob_ready),
        .ib_addr      (ib_addr),
        .ib_data      (ib_data),
        .ialloc_valid (ialloc_valid),
        .ialloc_addr  (ialloc_addr),
        .ichk_addr1   (ichk_addr1),
        .ochk_busy1   (ochk_busy1),
        .ichk_addr2   (ichk_addr2),
        .ochk_busy2   (ochk_busy2),
        .ostall_a     (ostall_a),
        .oproto_err   (oproto_err),
        .owr_en3      (owr_en3),
        .owr_addr3    (owr_addr3),
        .owr_data3    (owr_data3)
`ifdef RISCV_REGFILE_WR_FWD_EN
        ,
        .ofwd_hit1    (h1),
        .ofwd_data1   (),
        .ofwd_hit2    (h2),
        .ofwd_data2   (fd2)
`endif
    );

`ifndef RISCV_REGFILE_WR_FWD_EN
    assign h1  = 1'b0;
    assign h2  = 1'b0;
    assign fd2 = '0;
`endif

    typedef struct {
        string      nm;
        logic [6:0] m;
        logic [6:0] v;
        logic [DW-1:0] fd2;
    } st_t;

    typedef struct {
        string         nm;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    st_t stq[$];
    wr_t wq[$];
    int  n_vec = 0;
    int  n_err = 0;

    logic [6:0] act;
    assign act = {h1, h2, ob_ready, ostall_a, oproto_err, ochk_busy1, ochk_busy2};

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge iclk) begin
        st_t s;
        wr_t w;
        if (stq.size() != 0) begin
            s = stq.pop_front();
            n_vec++;
            if ((act & s.m) !== (s.v & s.m)) begin
                n_err++;
                $display("FAIL %s: status {h1,h2,rdy,stall,perr,b1,b2} actual=%b required=%b (mask %b)",
                         s.nm, act, s.v, s.m);
            end
            if (s.m[5] && s.v[5]) begin
                n_vec++;
                if (fd2 !== s.fd2) begin
                    n_err++;
                    $display("FAIL %s_fwd_data: actual=%h required=%h", s.nm, fd2, s.fd2);
                end
            end
        end
        if (owr_en3 !== 1'b0) begin
            n_vec++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: actual en=%b addr=%0d data=%h required no write",
                         owr_en3, owr_addr3, owr_data3);
            end else begin
                w = wq.pop_front();
                if (owr_en3 !== 1'b1 || owr_addr3 !== w.a || owr_data3 !== w.d) begin
                    n_err++;
                    $display("FAIL %s: write actual en=%b addr=%0d data=%h required addr=%0d data=%h",
                             w.nm, owr_en3, owr_addr3, owr_data3, w.a, w.d);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        ia_valid     = 1'b0;
        ia_addr      = '0;
        ia_data      = '0;
        ib_valid     = 1'b0;
        ib_addr      = '0;
        ib_data      = '0;
        ialloc_valid = 1'b0;
        ialloc_addr  = '0;
        ichk_addr1   = '0;
        ichk_addr2   = '0;
    endtask

    task automatic drv_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ia_valid = 1'b1;
        ia_addr  = a;
        ia_data  = d;
    endtask

    task automatic drv_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ib_valid = 1'b1;
        ib_addr  = a;
        ib_data  = d;
    endtask

    task automatic expw(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.nm = nm;
        w.a  = a;
        w.d  = d;
        wq.push_back(w);
    endtask

    task automatic step(input string nm, input logic [6:0] m, input logic [6:0] v,
                        input logic [DW-1:0] f = '0);
        st_t s;
        s.nm  = nm;
        s.m   = m;
        s.v   = v;
        s.fd2 = f;
        stq.push_back(s);
        @(posedge iclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] b_hit_m;
        logic [6:0] b_hit_v;

`ifdef RISCV_REGFILE_WR_FWD_EN
        b_hit_v = 7'b0;      // busy masked by the forwarded B write
`else
        b_hit_v = V_B1;      // still busy until the cycle after the B write
`endif
        b_hit_m = M_B1;

        // ---------------- reset ----------------
        irst = 1'b1;
        idle();
        drv_a(5'd5, 32'h1111);
        drv_b(5'd6, 32'h2222);
        ichk_addr1 = 5'd5;
        @(posedge iclk);
        #1;
        step("reset_outputs", M_ALL, 7'b0);
        irst = 1'b0;

        // ---------------- 1: A vs B same cycle ----------------
        idle(); drv_a(5'd5, 32'hAAAA); drv_b(5'd6, 32'hBBBB);
        expw("t1_a_write", 5'd5, 32'hAAAA);
        step("t1_a_wins", M_RSP, 7'b0);
        ia_valid = 1'b0;
        expw("t1_b_write", 5'd6, 32'hBBBB);
        step("t1_b_granted", M_RSP, V_RDY);
        idle();
        step("t1_idle", M_RSP, V_RDY);

        // ---------------- 2: starvation -> STALL ----------------
        idle(); drv_b(5'd2, 32'h22);
        drv_a(5'd1, 32'h1); expw("t2_a1", 5'd1, 32'h1); step("t2_lose1", M_RSP, 7'b0);
        drv_a(5'd3, 32'h3); expw("t2_a3", 5'd3, 32'h3); step("t2_lose2", M_RSP, 7'b0);
        drv_a(5'd4, 32'h4); expw("t2_a4", 5'd4, 32'h4); step("t2_lose3", M_RSP, 7'b0);
        ia_valid = 1'b0;
        expw("t2_b_write", 5'd2, 32'h22);
        step("t2_stall_grant", M_RSP, V_RDY | V_STL);
        idle();
        step("t2_stall_drop", M_RSP, V_RDY);

        // ---------------- 3: scoreboard ----------------
        idle(); ialloc_valid = 1'b1; ialloc_addr = 5'd7; ichk_addr1 = 5'd7;
        step("t3_alloc_same_cycle", M_RSP | M_B1, V_RDY);
        idle(); ichk_addr1 = 5'd7; ichk_addr2 = 5'd6;
        step("t3_busy_set", M_RSP | M_B1 | M_B2, V_RDY | V_B1);
        idle(); ichk_addr1 = 5'd7; drv_b(5'd7, 32'h77);
        expw("t3_b_write7", 5'd7, 32'h77);
        step("t3_busy_during_bwrite", M_RSP | b_hit_m, V_RDY | b_hit_v);
        idle(); ichk_addr1 = 5'd7;
        step("t3_busy_cleared", M_RSP | M_B1, V_RDY);
        idle(); ialloc_valid = 1'b1; ialloc_addr = 5'd7;
        step("t3_realloc", M_RSP, V_RDY);
        idle(); ialloc_valid = 1'b1; ialloc_addr = 5'd7; ichk_addr1 = 5'd7;
        drv_b(5'd7, 32'h7070);
        expw("t3_b_write7_set", 5'd7, 32'h7070);
        step("t3_set_and_clear", M_RSP | b_hit_m, V_RDY | b_hit_v);
        idle(); ichk_addr1 = 5'd7; ichk_addr2 = 5'd7;
        step("t3_set_wins", M_RSP | M_B1 | M_B2, V_RDY | V_B1 | V_B2);
        idle(); drv_b(5'd7, 32'h1);
        expw("t3_cleanup", 5'd7, 32'h1);
        step("t3_cleanup", M_RSP, V_RDY);
        idle(); ichk_addr1 = 5'd7;
        step("t3_clean", M_B1, 7'b0);

        // ---------------- 4: x0 ----------------
        idle(); drv_a(5'd0, 32'h1234);
        step("t4_a_x0_no_write", M_RSP, 7'b0);
        idle(); ialloc_valid = 1'b1; ialloc_addr = 5'd0;
        step("t4_alloc_x0", M_RSP | M_B1 | M_B2, V_RDY);
        idle();
        step("t4_x0_never_busy", M_RSP | M_B1 | M_B2, V_RDY);
        idle(); drv_b(5'd0, 32'h5555);
        step("t4_b_x0_handshake", M_RSP, V_RDY);
        idle();
        step("t4_idle", M_RSP, V_RDY);

        // ---------------- 5: protocol violation in STALL ----------------
        idle(); drv_b(5'd13, 32'hD13);
        drv_a(5'd10, 32'hA10); expw("t5_a10", 5'd10, 32'hA10); step("t5_lose1", M_RSP, 7'b0);
        drv_a(5'd11, 32'hA11); expw("t5_a11", 5'd11, 32'hA11); step("t5_lose2", M_RSP, 7'b0);
        drv_a(5'd12, 32'hA12); expw("t5_a12", 5'd12, 32'hA12); step("t5_lose3", M_RSP, 7'b0);
        drv_a(5'd14, 32'hE14); expw("t5_a_in_stall", 5'd14, 32'hE14);
        step("t5_violation", M_RSP, V_STL);
        ia_valid = 1'b0;
        expw("t5_b_write", 5'd13, 32'hD13);
        step("t5_proto_pulse", M_RSP, V_RDY | V_STL | V_ERR);
        idle();
        step("t5_recovered", M_RSP, V_RDY);

        // ---------------- 6: reset mid-STALL ----------------
        idle(); ialloc_valid = 1'b1; ialloc_addr = 5'd20;
        step("t6_alloc20", M_RSP, V_RDY);
        idle(); drv_b(5'd18, 32'h18); ichk_addr1 = 5'd20;
        drv_a(5'd15, 32'h15); expw("t6_a15", 5'd15, 32'h15); step("t6_lose1", M_RSP | M_B1, V_B1);
        drv_a(5'd16, 32'h16); expw("t6_a16", 5'd16, 32'h16); step("t6_lose2", M_RSP | M_B1, V_B1);
        drv_a(5'd17, 32'h17); expw("t6_a17", 5'd17, 32'h17); step("t6_lose3", M_RSP | M_B1, V_B1);
        ia_valid = 1'b0; ib_valid = 1'b0;
        step("t6_in_stall", V_STL | V_ERR | M_B1, V_STL | V_B1);
        irst = 1'b1;
        drv_a(5'd19, 32'h19); drv_b(5'd18, 32'h18);
        ialloc_valid = 1'b1; ialloc_addr = 5'd21; ichk_addr2 = 5'd21;
        step("t6_rst_outputs", M_ALL, 7'b0);
        step("t6_rst_held", M_ALL, 7'b0);
        irst = 1'b0;
        idle(); ichk_addr1 = 5'd20; ichk_addr2 = 5'd21;
        step("t6_after_reset", M_ALL, V_RDY);
        drv_a(5'd19, 32'h19); drv_b(5'd18, 32'h18);
        expw("t6_a19", 5'd19, 32'h19);
        step("t6_arb_a_wins", M_RSP, 7'b0);
        ia_valid = 1'b0;
        expw("t6_b18", 5'd18, 32'h18);
        step("t6_arb_b_granted", M_RSP, V_RDY);

        // ---------------- 7: B write hitting a lookup ----------------
        idle(); ialloc_valid = 1'b1; ialloc_addr = 5'd9;
        step("t7_alloc9", M_RSP, V_RDY);
        idle(); drv_b(5'd9, 32'hBBBB); ichk_addr1 = 5'd3; ichk_addr2 = 5'd9;
        expw("t7_b_write9", 5'd9, 32'hBBBB);
`ifdef RISCV_REGFILE_WR_FWD_EN
        step("t7_fwd_hit2", M_RSP | M_B2 | M_H, V_RDY | V_H2, 32'hBBBB);
`else
        step("t7_busy_until_after", M_RSP | M_B2, V_RDY | V_B2);
`endif
        idle(); ichk_addr2 = 5'd9;
        step("t7_cleared", M_RSP | M_B2 | M_H, V_RDY);

        idle();
        @(negedge iclk);
        #1;
        while (wq.size() != 0) begin
            wr_t w;
            w = wq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: write actual=missing required addr=%0d data=%h", w.nm, w.a, w.d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_riscv_dp_regfile_wr_arb
`default_nettype wire
